// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D-cache request port between issued loads and retiring stores
//
// One registered request stage feeds the cache. Stores win ties unless a waiting load has
// lost STARVE_LIMIT times in a row. Outstanding MSHRs are counted and a registered stall is
// returned to the load issue buffer. Branch mispredicts squash staged or incoming loads.
//
// Ports:
//   clock, reset                      clock; synchronous active-high reset
//   ld_valid_i/addr/tag/bmask         load request from the load issue buffer
//   ld_ready_o                        load accepted this cycle
//   st_valid_i/addr/data/size         retiring store request
//   st_ready_o                        store accepted this cycle
//   clean_brat_en/num                 mispredict: squash loads carrying mask bit num
//   clean_bit_en/num                  correct predict: clear mask bit num
//   port_req_o, port_is_st_o          request stage valid / kind toward the D-cache
//   port_addr/data/size/tag_o         request stage payload
//   port_rdy_i                        cache takes the stage this cycle
//   mshr_alloc_i, mshr_free_i         MSHR allocate / release events
//   mshr_cnt_o, mshr_stall_o          outstanding MSHRs / registered load stall
//   perf_ld_stall_o, perf_starve_o    only with DCACHE_ARB_PERF_EN: stalled-load cycles,
//                                     forced load grants
//
// Build option: define DCACHE_ARB_PERF_EN to add the two performance counters.
module dcache_port_arbiter #(
    parameter int MSHR_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int TAG_W        = 4,
    parameter int BMASK_W      = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ld_valid_i,
    input  logic [31:0]                     ld_addr_i,
    input  logic [TAG_W-1:0]                ld_tag_i,
    input  logic [BMASK_W-1:0]              ld_bmask_i,
    output logic                            ld_ready_o,
    input  logic                            st_valid_i,
    input  logic [31:0]                     st_addr_i,
    input  logic [31:0]                     st_data_i,
    input  logic [1:0]                      st_size_i,
    output logic                            st_ready_o,
    input  logic                            clean_brat_en,
    input  logic [$clog2(BMASK_W)-1:0]      clean_brat_num,
    input  logic                            clean_bit_en,
    input  logic [$clog2(BMASK_W)-1:0]      clean_bit_num,
    output logic                            port_req_o,
    output logic                            port_is_st_o,
    output logic [31:0]                     port_addr_o,
    output logic [31:0]                     port_data_o,
    output logic [1:0]                      port_size_o,
    output logic [TAG_W-1:0]                port_tag_o,
    input  logic                            port_rdy_i,
    input  logic                            mshr_alloc_i,
    input  logic                            mshr_free_i,
    output logic [$clog2(MSHR_DEPTH+1)-1:0] mshr_cnt_o,
    output logic                            mshr_stall_o
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [31:0]                     perf_ld_stall_o,
    output logic [31:0]                     perf_starve_o
`endif
);
    localparam int CNT_W = $clog2(MSHR_DEPTH + 1);
    localparam int SV_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MSHR_DEPTH);
    localparam logic [SV_W-1:0]  LIMIT_C = SV_W'(STARVE_LIMIT);

    logic [BMASK_W-1:0] bmask, clr_mask;
    logic [SV_W-1:0]    starve;
    logic [CNT_W-1:0]   cnt_next;
    logic stage_free, ld_elig, forced, grant_st, grant_ld, ld_drop, squash, next_valid, next_ld;

    always_comb begin
        stage_free = !port_req_o | port_rdy_i;
        ld_elig    = ld_valid_i & !mshr_stall_o;
        forced     = starve == LIMIT_C;
        grant_st   = !reset & stage_free & st_valid_i & !(ld_elig & forced);
        grant_ld   = !reset & stage_free & ld_elig & (!st_valid_i | forced);
        clr_mask   = clean_bit_en ? BMASK_W'(1) << clean_bit_num : '0;
        // A mispredicted incoming load is handshaken (ready) but never staged.
        ld_drop    = clean_brat_en & ld_bmask_i[clean_brat_num];
        // A staged load is only recalled if the cache is not taking it this cycle.
        squash     = clean_brat_en & port_req_o & !port_is_st_o & bmask[clean_brat_num] & !port_rdy_i;
        next_valid = grant_st | (grant_ld & !ld_drop) | (!stage_free & !squash);
        next_ld    = (grant_ld & !ld_drop) | (!stage_free & !squash & !port_is_st_o);
        cnt_next   = (mshr_alloc_i & !mshr_free_i & (mshr_cnt_o != DEPTH_C)) ? mshr_cnt_o + CNT_W'(1) :
                     (mshr_free_i & !mshr_alloc_i & (mshr_cnt_o != '0))    ? mshr_cnt_o - CNT_W'(1) :
                     mshr_cnt_o;
    end

    assign ld_ready_o = grant_ld;
    assign st_ready_o = grant_st;

    always_ff @(posedge clock) begin
        if (reset) begin
            port_req_o   <= 1'b0;
            port_is_st_o <= 1'b0;
            port_addr_o  <= '0;
            port_data_o  <= '0;
            port_size_o  <= '0;
            port_tag_o   <= '0;
            bmask        <= '0;
            starve       <= '0;
            mshr_cnt_o   <= '0;
            mshr_stall_o <= 1'b0;
        end else begin
            port_req_o <= next_valid;
            if (grant_st) begin
                port_is_st_o <= 1'b1;
                port_addr_o  <= st_addr_i;
                port_data_o  <= st_data_i;
                port_size_o  <= st_size_i;
                port_tag_o   <= '0;
                bmask        <= '0;
            end else if (grant_ld & !ld_drop) begin
                port_is_st_o <= 1'b0;
                port_addr_o  <= ld_addr_i;
                port_data_o  <= '0;
                port_size_o  <= 2'd2;
                port_tag_o   <= ld_tag_i;
                bmask        <= ld_bmask_i & ~clr_mask;
            end else begin
                bmask <= bmask & ~clr_mask;
            end
            // A store can only beat an eligible load below the limit, so the increment saturates.
            if (stage_free)
                starve <= (ld_elig & grant_st) ? starve + SV_W'(1) : '0;
            mshr_cnt_o   <= cnt_next;
            mshr_stall_o <= ({1'b0, cnt_next} + {{CNT_W{1'b0}}, next_ld}) >= {1'b0, DEPTH_C};
        end
    end

`ifdef DCACHE_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ld_stall_o <= '0;
            perf_starve_o   <= '0;
        end else begin
            if (ld_valid_i & mshr_stall_o)
                perf_ld_stall_o <= perf_ld_stall_o + 32'd1;
            if (grant_ld & forced & st_valid_i)
                perf_starve_o <= perf_starve_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        ld_valid_i, st_valid_i, ld_ready_o, st_ready_o;
    logic [31:0] ld_addr_i, st_addr_i, st_data_i;
    logic [3:0]  ld_tag_i, ld_bmask_i;
    logic [1:0]  st_size_i, clean_brat_num, clean_bit_num;
    logic        clean_brat_en, clean_bit_en;
    logic        port_req_o, port_is_st_o, port_rdy_i;
    logic [31:0] port_addr_o, port_data_o;
    logic [1:0]  port_size_o;
    logic [3:0]  port_tag_o;
    logic        mshr_alloc_i, mshr_free_i, mshr_stall_o;
    logic [2:0]  mshr_cnt_o;
`ifdef DCACHE_ARB_PERF_EN
    logic [31:0] perf_ld_stall_o, perf_starve_o;
`endif
    int errors = 0;
    int checks = 0;

    dcache_port_arbiter dut (
        .clock(clock), .reset(reset),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_tag_i(ld_tag_i),
        .ld_bmask_i(ld_bmask_i), .ld_ready_o(ld_ready_o),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_size_i(st_size_i), .st_ready_o(st_ready_o),
        .clean_brat_en(clean_brat_en), .clean_brat_num(clean_brat_num),
        .clean_bit_en(clean_bit_en), .clean_bit_num(clean_bit_num),
        .port_req_o(port_req_o), .port_is_st_o(port_is_st_o), .port_addr_o(port_addr_o),
        .port_data_o(port_data_o), .port_size_o(port_size_o), .port_tag_o(port_tag_o),
        .port_rdy_i(port_rdy_i), .mshr_alloc_i(mshr_alloc_i), .mshr_free_i(mshr_free_i),
        .mshr_cnt_o(mshr_cnt_o), .mshr_stall_o(mshr_stall_o)
`ifdef DCACHE_ARB_PERF_EN
        , .perf_ld_stall_o(perf_ld_stall_o), .perf_starve_o(perf_starve_o)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        ld_valid_i = 1'b1; ld_addr_i = 32'h0; ld_tag_i = 4'h0; ld_bmask_i = 4'h0;
        st_valid_i = 1'b1; st_addr_i = 32'h0; st_data_i = 32'h0; st_size_i = 2'd2;
        clean_brat_en = 1'b0; clean_brat_num = 2'd0; clean_bit_en = 1'b0; clean_bit_num = 2'd0;
        port_rdy_i = 1'b1; mshr_alloc_i = 1'b0; mshr_free_i = 1'b0;
        #1;
        chk("reset_ld_ready", ld_ready_o, 0);
        chk("reset_st_ready", st_ready_o, 0);
        tick; tick;
        chk("reset_req", port_req_o, 0);
        chk("reset_addr", port_addr_o, 0);
        chk("reset_cnt", mshr_cnt_o, 0);
        chk("reset_stall", mshr_stall_o, 0);
        ld_valid_i = 1'b0; st_valid_i = 1'b0; reset = 1'b0;
        tick;

        // single load
        ld_valid_i = 1'b1; ld_addr_i = 32'h100; ld_tag_i = 4'd3;
        #1;
        chk("ld_ready", ld_ready_o, 1);
        tick;
        ld_valid_i = 1'b0;
        chk("ld_req", port_req_o, 1);
        chk("ld_is_st", port_is_st_o, 0);
        chk("ld_addr", port_addr_o, 32'h100);
        chk("ld_tag", port_tag_o, 3);
        tick;
        chk("ld_drained", port_req_o, 0);

        // starvation: 8 store grants then a forced load grant
        ld_valid_i = 1'b1; ld_addr_i = 32'h180; ld_tag_i = 4'd1;
        st_valid_i = 1'b1; st_addr_i = 32'h200; st_data_i = 32'h55;
        for (int k = 0; k < 18; k++) begin
            #1;
            chk("starve_ld_ready", ld_ready_o, (k % 9 == 8) ? 1 : 0);
            chk("starve_st_ready", st_ready_o, (k % 9 == 8) ? 0 : 1);
            tick;
            chk("starve_is_st", port_is_st_o, (k % 9 == 8) ? 0 : 1);
        end
        ld_valid_i = 1'b0; st_valid_i = 1'b0;
        tick;

        // MSHR fill to depth
        mshr_alloc_i = 1'b1;
        tick; tick; tick;
        chk("mshr_cnt3", mshr_cnt_o, 3);
        chk("mshr_stall3", mshr_stall_o, 0);
        tick;
        chk("mshr_cnt4", mshr_cnt_o, 4);
        chk("mshr_stall4", mshr_stall_o, 1);
        tick;
        chk("mshr_alloc_full", mshr_cnt_o, 4);
        mshr_alloc_i = 1'b0; ld_valid_i = 1'b1;
        #1;
        chk("mshr_ld_blocked", ld_ready_o, 0);
        ld_valid_i = 1'b0; mshr_free_i = 1'b1;
        tick;
        chk("mshr_free_cnt", mshr_cnt_o, 3);
        chk("mshr_free_stall", mshr_stall_o, 0);
        tick;
        chk("mshr_cnt2", mshr_cnt_o, 2);
        mshr_alloc_i = 1'b1;
        tick;
        chk("mshr_alloc_free", mshr_cnt_o, 2);
        mshr_alloc_i = 1'b0;
        tick; tick; tick;
        chk("mshr_free_zero", mshr_cnt_o, 0);
        mshr_free_i = 1'b0;

        // staged load squashed while cache stalls
        port_rdy_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h300; ld_tag_i = 4'd5; ld_bmask_i = 4'b0010;
        tick;
        ld_valid_i = 1'b0;
        chk("sq_staged", port_req_o, 1);
        clean_brat_en = 1'b1; clean_brat_num = 2'd1;
        tick;
        chk("sq_stage_gone", port_req_o, 0);
        // incoming load with the mispredicted bit: handshaken, dropped
        ld_valid_i = 1'b1;
        #1;
        chk("sq_in_ready", ld_ready_o, 1);
        tick;
        chk("sq_in_dropped", port_req_o, 0);
        // stores are never squashed
        ld_valid_i = 1'b0; st_valid_i = 1'b1; st_addr_i = 32'h400;
        tick;
        st_valid_i = 1'b0;
        tick;
        chk("sq_store_kept", port_req_o, 1);
        chk("sq_store_is_st", port_is_st_o, 1);
        clean_brat_en = 1'b0; port_rdy_i = 1'b1;
        tick;
        // cleared mask bit on capture protects the load from a later mispredict
        port_rdy_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h500; ld_bmask_i = 4'b0010;
        clean_bit_en = 1'b1; clean_bit_num = 2'd1;
        tick;
        clean_bit_en = 1'b0; ld_valid_i = 1'b0; clean_brat_en = 1'b1; clean_brat_num = 2'd1;
        tick;
        chk("clean_bit_kept", port_req_o, 1);
        chk("clean_bit_addr", port_addr_o, 32'h500);
        clean_brat_en = 1'b0; ld_bmask_i = 4'h0;

        // cache stalls 5 cycles: stage held, nothing accepted
        ld_valid_i = 1'b1; ld_addr_i = 32'h680; st_valid_i = 1'b1; st_addr_i = 32'h600; st_data_i = 32'hdead;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_ld_ready", ld_ready_o, 0);
            chk("hold_st_ready", st_ready_o, 0);
            tick;
            chk("hold_addr", port_addr_o, 32'h500);
        end
        port_rdy_i = 1'b1;
        #1;
        chk("hold_release_st", st_ready_o, 1);
        tick;
        ld_valid_i = 1'b0; st_valid_i = 1'b0;
        chk("hold_new_st", port_is_st_o, 1);
        chk("hold_new_addr", port_addr_o, 32'h600);
        chk("hold_new_data", port_data_o, 32'hdead);
        tick;

        // staged load counts toward the stall
        mshr_alloc_i = 1'b1;
        tick; tick; tick;
        mshr_alloc_i = 1'b0; port_rdy_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h700;
        tick;
        ld_valid_i = 1'b0;
        chk("stage_stall_cnt", mshr_cnt_o, 3);
        chk("stage_stall", mshr_stall_o, 1);
        port_rdy_i = 1'b1;
        tick;
        chk("stage_stall_drop", mshr_stall_o, 0);

        // reset mid-request drops the stage
        port_rdy_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h800;
        tick;
        ld_valid_i = 1'b0;
        chk("mid_staged", port_req_o, 1);
        reset = 1'b1;
        tick;
        chk("mid_reset_req", port_req_o, 0);
        chk("mid_reset_cnt", mshr_cnt_o, 0);
        reset = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
